// File: rtl/regfile_writeback_arbiter.sv
// Writeback arbiter: merges ALU and buffered long-latency results onto the register file
// write port and tracks pending LL writes. Optional macro WB_BYPASS_EN adds byp_* outputs.
module regfile_writeback_arbiter #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDR_WIDTH    = 5,
   parameter int unsigned NUM_REGS      = 32,
   parameter int unsigned LL_FIFO_DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             alu_valid,
   input  logic [ADDR_WIDTH-1:0]            alu_rd,
   input  logic [DATA_WIDTH-1:0]            alu_data,
   output logic                             alu_stall,
   input  logic                             ll_issue,
   input  logic [ADDR_WIDTH-1:0]            ll_issue_rd,
   input  logic                             ll_valid,
   output logic                             ll_ready,
   input  logic [ADDR_WIDTH-1:0]            ll_rd,
   input  logic [DATA_WIDTH-1:0]            ll_data,
   input  logic [ADDR_WIDTH-1:0]            chk_rs1,
   input  logic [ADDR_WIDTH-1:0]            chk_rs2,
   input  logic [ADDR_WIDTH-1:0]            chk_rd,
   output logic                             hazard,
   output logic [ADDR_WIDTH-1:0]            reg_num_w,
   output logic [DATA_WIDTH-1:0]            w_data,
   output logic                             ctrl_reg_w,
   output logic [$clog2(LL_FIFO_DEPTH):0]   ll_count
`ifdef WB_BYPASS_EN
   ,
   output logic                             byp_valid,
   output logic [ADDR_WIDTH-1:0]            byp_rd,
   output logic [DATA_WIDTH-1:0]            byp_data
`endif
);

   localparam int unsigned PTR_W = $clog2(LL_FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [ADDR_WIDTH-1:0] fifo_rd_q   [LL_FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data_q [LL_FIFO_DEPTH];

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [NUM_REGS-1:0]   sb_q, sb_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] wnum_q, wnum_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

   logic                  full, empty, pop, push, alu_take;
   logic [ADDR_WIDTH-1:0] head_rd;
   logic [DATA_WIDTH-1:0] head_data;
   logic [NUM_REGS-1:0]   clr_mask, set_mask, chk_mask;

   // Source selection, FIFO bookkeeping, scoreboard update and hazard
   always_comb begin
      full      = (count_q == CNT_W'(LL_FIFO_DEPTH));
      empty     = (count_q == '0);
      head_rd   = fifo_rd_q[rd_ptr_q];
      head_data = fifo_data_q[rd_ptr_q];
      pop       = 1'b0;
      alu_take  = 1'b0;
      alu_stall = 1'b0;

      // A full FIFO always drains; an rd=0 ALU result is consumed, never stalled
      if (alu_valid && full) begin
         pop       = 1'b1;
         alu_stall = (alu_rd != '0);
      end else if (alu_valid && (alu_rd != '0)) begin
         alu_take = 1'b1;
      end else if (!empty) begin
         pop = 1'b1;
      end

      ll_ready = !full || pop;
      push     = ll_valid && ll_ready;

      we_d    = 1'b0;
      wnum_d  = wnum_q;
      wdata_d = wdata_q;
      if (alu_take) begin
         we_d    = 1'b1;
         wnum_d  = alu_rd;
         wdata_d = alu_data;
      end else if (pop && (head_rd != '0)) begin
         we_d    = 1'b1;
         wnum_d  = head_rd;
         wdata_d = head_data;
      end

      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         clr_mask[i] = pop && (head_rd == ADDR_WIDTH'(i));
         set_mask[i] = ll_issue && (ll_issue_rd == ADDR_WIDTH'(i));
         chk_mask[i] = (chk_rs1 == ADDR_WIDTH'(i)) || (chk_rs2 == ADDR_WIDTH'(i)) ||
                       (chk_rd == ADDR_WIDTH'(i));
      end
      set_mask[0] = 1'b0;

      // Set wins over clear; a bit being popped already reads as clear
      sb_d    = (sb_q & ~clr_mask) | set_mask;
      sb_d[0] = 1'b0;
      hazard  = |(sb_q & ~clr_mask & chk_mask);
   end

   // Control and write-port registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         sb_q     <= '0;
         we_q     <= 1'b0;
         wnum_q   <= '0;
         wdata_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         sb_q     <= sb_d;
         we_q     <= we_d;
         wnum_q   <= wnum_d;
         wdata_q  <= wdata_d;
      end
   end

   // FIFO storage; contents are don't-care while unoccupied
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd_q[wr_ptr_q]   <= ll_rd;
         fifo_data_q[wr_ptr_q] <= ll_data;
      end
   end

   assign reg_num_w  = wnum_q;
   assign w_data     = wdata_q;
   assign ctrl_reg_w = we_q;
   assign ll_count   = count_q;

`ifdef WB_BYPASS_EN
   assign byp_valid = we_q;
   assign byp_rd    = wnum_q;
   assign byp_data  = wdata_q;
`endif

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Scoreboard bench for regfile_writeback_arbiter: queue-based reference model predicts
// writes and combinational flags; an independent monitor checks the write port.
`timescale 1ns/1ps
module tb_regfile_writeback_arbiter;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned NR    = 32;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          alu_valid, alu_stall, ll_issue, ll_valid, ll_ready, hazard, ctrl_reg_w;
   logic [AW-1:0] alu_rd, ll_issue_rd, ll_rd, chk_rs1, chk_rs2, chk_rd, reg_num_w;
   logic [DW-1:0] alu_data, ll_data, w_data;
   logic [CW-1:0] ll_count;
`ifdef WB_BYPASS_EN
   logic          byp_valid;
   logic [AW-1:0] byp_rd;
   logic [DW-1:0] byp_data;
`endif

   regfile_writeback_arbiter #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .LL_FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
      .ll_issue(ll_issue), .ll_issue_rd(ll_issue_rd),
      .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
      .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd), .hazard(hazard),
      .reg_num_w(reg_num_w), .w_data(w_data), .ctrl_reg_w(ctrl_reg_w), .ll_count(ll_count)
`ifdef WB_BYPASS_EN
      , .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { logic [AW-1:0] rd; logic [DW-1:0] data; } ll_t;
   typedef struct { logic [AW-1:0] rd; logic [DW-1:0] data; int cyc; } wr_t;

   ll_t m_fifo[$];
   bit  m_pend[NR];
   wr_t exp_q[$];
   bit  m_stall = 1'b0;
   bit  m_ready = 1'b1;
   int  checks = 0;
   int  failures = 0;
   int  cyc = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Write-port monitor
   always @(negedge clk) begin
      wr_t e;
      if (ctrl_reg_w === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("spurious_write", 64'(ctrl_reg_w), 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("wr_rd", 64'(reg_num_w), 64'(e.rd));
            chk("wr_data", 64'(w_data), 64'(e.data));
            chk("wr_cycle", 64'(cyc), 64'(e.cyc));
         end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e = exp_q.pop_front();
         chk("missing_write", 64'(ctrl_reg_w), 64'd1);
      end
   end

   task automatic push_wr(input logic [AW-1:0] rd, input logic [DW-1:0] data);
      wr_t w;
      w.rd = rd; w.data = data; w.cyc = cyc + 1;
      exp_q.push_back(w);
   endtask

   // One clock of the reference model against the inputs currently applied
   task automatic step();
      bit  full, pop, take, stall, ready, haz;
      int  cnt;
      ll_t h, n;
      #1;
      cnt   = m_fifo.size();
      full  = (cnt == DEPTH);
      pop   = 1'b0; take = 1'b0; stall = 1'b0;
      if (alu_valid && full) begin
         pop = 1'b1; stall = (alu_rd != 0);
      end else if (alu_valid && alu_rd != 0) take = 1'b1;
      else if (cnt > 0) pop = 1'b1;
      ready = !full || pop;
      if (pop) begin
         h = m_fifo.pop_front();
         m_pend[h.rd] = 1'b0;
         if (h.rd != 0) push_wr(h.rd, h.data);
      end else if (take) push_wr(alu_rd, alu_data);
      haz = m_pend[chk_rs1] | m_pend[chk_rs2] | m_pend[chk_rd];
      chk("ll_ready", 64'(ll_ready), 64'(ready));
      chk("alu_stall", 64'(alu_stall), 64'(stall));
      chk("hazard", 64'(hazard), 64'(haz));
      chk("ll_count", 64'(ll_count), 64'(cnt));
      if (ll_valid && ready) begin
         n.rd = ll_rd; n.data = ll_data;
         m_fifo.push_back(n);
      end
      if (ll_issue && ll_issue_rd != 0) m_pend[ll_issue_rd] = 1'b1;
      m_stall = stall;
      m_ready = ready;
      @(negedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      ll_issue = 1'b0; ll_issue_rd = '0;
      ll_valid = 1'b0; ll_rd = '0; ll_data = '0;
      chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ctrl_reg_w", 64'(ctrl_reg_w), 64'd0);
      chk("rst_reg_num_w", 64'(reg_num_w), 64'd0);
      chk("rst_w_data", 64'(w_data), 64'd0);
      chk("rst_ll_count", 64'(ll_count), 64'd0);
      chk("rst_ll_ready", 64'(ll_ready), 64'd1);
      chk("rst_alu_stall", 64'(alu_stall), 64'd0);
      chk("rst_hazard", 64'(hazard), 64'd0);
      rst = 1'b0;
      step();
      step();

      // ALU write and rd=0 suppression
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; step();
      alu_rd = 5'd0; alu_data = 32'h11111111; step();
      alu_valid = 1'b0; step();

      // LL hazard and 2-cycle write latency
      ll_issue = 1'b1; ll_issue_rd = 5'd7; step();
      ll_issue = 1'b0; chk_rs1 = 5'd7; step();
      ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h1234; step();
      ll_valid = 1'b0; step();
      step();
      chk_rs1 = 5'd0;

      // Fill FIFO under continuous ALU traffic, then drain
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = $urandom;
      for (int i = 0; i < 12; i++) begin
         if (i < 5) begin
            ll_valid = 1'b1; ll_rd = AW'(10 + i); ll_data = DW'(32'hA0 + i);
         end else ll_valid = 1'b0;
         step();
         if (!m_stall) begin
            alu_rd = AW'(1 + (i % 4)); alu_data = $urandom;
         end
      end
      alu_valid = 1'b0; ll_valid = 1'b0;
      repeat (6) step();

      // Same-cycle set and clear of the same scoreboard bit
      ll_issue = 1'b1; ll_issue_rd = 5'd9; step();
      ll_issue = 1'b0; ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h99; step();
      ll_valid = 1'b0; ll_issue = 1'b1; ll_issue_rd = 5'd9; step();
      ll_issue = 1'b0; chk_rs2 = 5'd9; step();
      chk_rs2 = 5'd0; step();

      // Reset with buffered results and a pending mark
      ll_issue = 1'b1; ll_issue_rd = 5'd3; step();
      ll_issue = 1'b0; alu_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         alu_rd = AW'(20 + i); alu_data = $urandom;
         ll_valid = 1'b1; ll_rd = AW'(3 + i); ll_data = $urandom;
         step();
      end
      alu_valid = 1'b0; ll_valid = 1'b0; chk_rs1 = 5'd3;
      chk("pre_rst_count", 64'(ll_count), 64'(m_fifo.size()));
      rst = 1'b1;
      #1;
      chk("midrst_ll_count", 64'(ll_count), 64'd0);
      chk("midrst_hazard", 64'(hazard), 64'd0);
      chk("midrst_ctrl_reg_w", 64'(ctrl_reg_w), 64'd0);
      chk("midrst_ll_ready", 64'(ll_ready), 64'd1);
      m_fifo.delete();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      @(negedge clk);
      #1;
      rst = 1'b0;
      repeat (4) step();
      chk_rs1 = 5'd0;

      // Randomized traffic; upstream holds stalled / refused offers
      for (int i = 0; i < 400; i++) begin
         if (!m_stall) begin
            alu_valid = ($urandom_range(0, 99) < 60);
            alu_rd    = AW'($urandom_range(0, 7));
            alu_data  = $urandom;
         end
         if (!(ll_valid && !m_ready)) begin
            ll_valid = ($urandom_range(0, 99) < 45);
            ll_rd    = AW'($urandom_range(0, 15));
            ll_data  = $urandom;
         end
         ll_issue    = ($urandom_range(0, 99) < 30);
         ll_issue_rd = AW'($urandom_range(0, 15));
         chk_rs1     = AW'($urandom_range(0, 15));
         chk_rs2     = AW'($urandom_range(0, 15));
         chk_rd      = AW'($urandom_range(0, 15));
         step();
      end
      idle_inputs();
      repeat (10) step();
      chk("pending_expected_writes", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
